// File: rtl/kiwi_pixel_rpc_server.sv
// kiwi_pixel_rpc_server
// Multi-client RPC server in front of a WIDTH x HEIGHT pixel frame buffer.
// Clients talk over independent 4-phase req/ack channels. One call is served
// at a time, and clients are picked round-robin. Supported calls are GET_ID,
// READ, WRITE and FILL (a whole-frame fill).
module kiwi_pixel_rpc_server #(
    parameter int          NCLIENTS = 2,
    parameter int          DATA_W   = 8,
    parameter int          WIDTH    = 16,
    parameter int          HEIGHT   = 16,
    parameter logic [31:0] ID_VALUE = 32'h00000019
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCLIENTS-1:0]        req,
    output logic [NCLIENTS-1:0]        ack,
    input  logic [2*NCLIENTS-1:0]      op,
    input  logic [32*NCLIENTS-1:0]     x,
    input  logic [32*NCLIENTS-1:0]     y,
    input  logic [DATA_W*NCLIENTS-1:0] wdata,
    output logic [32*NCLIENTS-1:0]     rdata,
    output logic [NCLIENTS-1:0]        err,
    output logic                       busy,
    output logic [31:0]                txn_count
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int IW   = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

    localparam logic [1:0] OP_GET_ID = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] OP_FILL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_FILL,
        S_ACK_HI,
        S_ACK_LO
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    // r_gnt is both the client being served and the round-robin pointer.
    logic [IW-1:0]            r_gnt;
    logic [IW-1:0]            w_pick;
    logic                     w_found;
    logic [NCLIENTS-1:0]      w_pend;

    logic [1:0]               w_op_sel;
    logic [31:0]              w_x_sel;
    logic [31:0]              w_y_sel;
    logic [DATA_W-1:0]        w_wd_sel;
    logic                     w_req_g;

    logic [1:0]               r_op;
    logic [31:0]              r_x;
    logic [31:0]              r_y;
    logic [DATA_W-1:0]        r_wdata;

    logic [AW-1:0]            r_fill_addr;
    logic [AW-1:0]            w_addr;
    logic                     w_oob;
    logic [DATA_W-1:0]        w_rd_pix;

    logic                     w_mem_we;
    logic [AW-1:0]            w_mem_addr;
    logic [DATA_W-1:0]        w_mem_wdata;

    logic [NCLIENTS-1:0]      r_ack;
    logic [NCLIENTS-1:0]      r_err;
    logic [32*NCLIENTS-1:0]   r_rdata;
    logic [31:0]              r_txn_count;

    // Frame buffer contents are deliberately left out of reset.
    logic [DATA_W-1:0]        r_mem [NPIX];

    assign w_pend   = req & ~r_ack;
    assign w_addr   = AW'(r_y * 32'(WIDTH) + r_x);
    assign w_oob    = (r_x >= 32'(WIDTH)) || (r_y >= 32'(HEIGHT));
    assign w_rd_pix = r_mem[w_addr];

    // Round-robin pick. The first pass looks above the last grant and the
    // second pass wraps around to the lowest pending client.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (!w_found && w_pend[i] && (IW'(i) > r_gnt)) begin
                w_found = 1'b1;
                w_pick  = IW'(i);
            end
        end
        for (int i = 0; i < NCLIENTS; i++) begin
            if (!w_found && w_pend[i]) begin
                w_found = 1'b1;
                w_pick  = IW'(i);
            end
        end
    end

    // Argument mux for the client about to be granted, plus the req level of
    // the client currently being served.
    always_comb begin
        w_op_sel = '0;
        w_x_sel  = '0;
        w_y_sel  = '0;
        w_wd_sel = '0;
        w_req_g  = 1'b0;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (w_pick == IW'(i)) begin
                w_op_sel = op[i*2 +: 2];
                w_x_sel  = x[i*32 +: 32];
                w_y_sel  = y[i*32 +: 32];
                w_wd_sel = wdata[i*DATA_W +: DATA_W];
            end
            if (r_gnt == IW'(i)) begin
                w_req_g = req[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. ACK_HI leaves only once ack is up and the client has
    // released req.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:   if (w_found) w_next_state = S_EXEC;
            S_EXEC:   w_next_state = (r_op == OP_FILL) ? S_FILL : S_ACK_HI;
            S_FILL:   if (r_fill_addr == AW'(NPIX - 1)) w_next_state = S_ACK_HI;
            S_ACK_HI: if ((r_ack != '0) && !w_req_g) w_next_state = S_ACK_LO;
            S_ACK_LO: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Capture the granted client's arguments. They stay frozen for the whole call.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_found) begin
            r_op    <= w_op_sel;
            r_x     <= w_x_sel;
            r_y     <= w_y_sel;
            r_wdata <= w_wd_sel;
        end
    end

    // Control and response registers: grant pointer, fill address, ack,
    // rdata/err and the call counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt       <= IW'(NCLIENTS - 1);
            r_fill_addr <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt       <= w_pick;
                        r_fill_addr <= '0;
                    end
                end
                S_EXEC: begin
                    for (int i = 0; i < NCLIENTS; i++) begin
                        if (r_gnt == IW'(i)) begin
                            case (r_op)
                                OP_GET_ID: begin
                                    r_rdata[i*32 +: 32] <= ID_VALUE;
                                    r_err[i]            <= 1'b0;
                                end
                                OP_READ: begin
                                    r_rdata[i*32 +: 32] <= w_oob ? 32'd0 : 32'(w_rd_pix);
                                    r_err[i]            <= w_oob;
                                end
                                OP_WRITE: begin
                                    if (w_oob) begin
                                        r_rdata[i*32 +: 32] <= 32'd0;
                                    end
                                    r_err[i] <= w_oob;
                                end
                                default: begin
                                    r_err[i] <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    r_fill_addr <= r_fill_addr + AW'(1);
                end
                S_ACK_HI: begin
                    if (r_ack == '0) begin
                        for (int i = 0; i < NCLIENTS; i++) begin
                            if (r_gnt == IW'(i)) begin
                                r_ack[i] <= 1'b1;
                            end
                        end
                        r_txn_count <= r_txn_count + 32'd1;
                    end else if (!w_req_g) begin
                        r_ack <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame buffer write port. It is shared by in-range WRITE calls and the
    // FILL sweep.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_addr;
        w_mem_wdata = r_wdata;
        if (r_state == S_EXEC && r_op == OP_WRITE && !w_oob) begin
            w_mem_we = 1'b1;
        end else if (r_state == S_FILL) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_fill_addr;
        end
        if (reset) begin
            w_mem_we = 1'b0;
        end
    end

    // Frame buffer storage.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign busy      = (r_state != S_IDLE);
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_kiwi_pixel_rpc_server.sv
// Scoreboard bench for kiwi_pixel_rpc_server. The stimulus pushes
// hand-computed responses. A negedge monitor pops one entry on every ack
// rising edge and compares it.
`timescale 1ns/1ps
module tb_kiwi_pixel_rpc_server;

    localparam int NC = 2;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req;
    logic [NC-1:0]     ack;
    logic [2*NC-1:0]   op;
    logic [32*NC-1:0]  x;
    logic [32*NC-1:0]  y;
    logic [DW*NC-1:0]  wdata;
    logic [32*NC-1:0]  rdata;
    logic [NC-1:0]     err;
    logic              busy;
    logic [31:0]       txn_count;

    typedef struct {
        int          c;
        logic [31:0] rd;
        logic        er;
        logic [31:0] txn;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [31:0]   exp_txn = 0;
    logic [NC-1:0] mon_prev = '0;

    always #5 clk = ~clk;

    kiwi_pixel_rpc_server #(
        .NCLIENTS(NC), .DATA_W(DW), .WIDTH(16), .HEIGHT(16), .ID_VALUE(32'h00000019)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .op(op), .x(x), .y(y),
        .wdata(wdata), .rdata(rdata), .err(err), .busy(busy), .txn_count(txn_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic push(input int c, input logic [31:0] rd, input logic er);
        exp_t e;
        exp_txn = exp_txn + 1;
        e.c = c; e.rd = rd; e.er = er; e.txn = exp_txn;
        sb.push_back(e);
    endtask

    // Monitor: checks every ack rising edge against the scoreboard and
    // enforces the one-hot ack rule.
    initial begin
        forever begin
            @(negedge clk);
            if ($countones(ack) > 1) begin
                total++; bad++;
                $display("FAIL ack_onehot: got %b want at most one bit", ack);
            end
            for (int c = 0; c < NC; c++) begin
                if (ack[c] && !mon_prev[c]) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ack: got client %0d want none", c);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("ack_client", 32'(c), 32'(e.c));
                        chk("rdata", rdata[c*32 +: 32], e.rd);
                        chk("err", 32'(err[c]), 32'(e.er));
                        chk("txn_count", txn_count, e.txn);
                    end
                end
            end
            mon_prev = ack;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic call(input int c, input logic [1:0] o, input logic [31:0] xx,
                        input logic [31:0] yy, input logic [7:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int n;
        wait_idle();
        op[c*2 +: 2]     = o;
        x[c*32 +: 32]    = xx;
        y[c*32 +: 32]    = yy;
        wdata[c*DW +: DW] = wd;
        push(c, exp_rd, exp_err);
        req[c] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[c] && n < 400);
        chk("latency", 32'(n), 32'(exp_lat));
        req[c] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[c] && n < 10);
        chk("ack_drop", 32'(ack[c]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_txn = 0;
    endtask

    task automatic chk_reset_state();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata0", rdata[31:0], 32'd0);
        chk("rst_rdata1", rdata[63:32], 32'd0);
    endtask

    initial begin
        int n;
        int rem [NC];
        reset = 1'b1; req = '0; op = '0; x = '0; y = '0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_state();

        // Basic calls and the write-then-read round trip.
        call(0, 2'd0, 0, 0, 8'h00, 32'h19, 1'b0, 3);
        call(0, 2'd2, 3, 5, 8'hA7, 32'h19, 1'b0, 3);
        call(1, 2'd1, 3, 5, 8'h00, 32'hA7, 1'b0, 3);
        call(0, 2'd2, 0, 0, 8'h11, 32'h19, 1'b0, 3);
        call(1, 2'd2, 0, 15, 8'h5A, 32'hA7, 1'b0, 3);
        call(1, 2'd1, 0, 15, 8'h00, 32'h5A, 1'b0, 3);

        // Out-of-range calls, including one whose address would alias onto (0,0).
        call(0, 2'd1, 16, 0, 8'h00, 32'h0, 1'b1, 3);
        call(0, 2'd2, 0, 16, 8'hFF, 32'h0, 1'b1, 3);
        call(0, 2'd1, 32'hFFFFFFF0, 0, 8'h00, 32'h0, 1'b1, 3);
        chk("hold_rdata1", rdata[63:32], 32'h5A);
        chk("hold_err1", 32'(err[1]), 32'd0);
        call(0, 2'd1, 0, 0, 8'h00, 32'h11, 1'b0, 3);
        call(1, 2'd1, 0, 15, 8'h00, 32'h5A, 1'b0, 3);
        call(0, 2'd0, 0, 0, 8'h00, 32'h19, 1'b0, 3);

        // req dropped before ack: the call still completes.
        wait_idle();
        op[3:2] = 2'd0;
        push(1, 32'h19, 1'b0);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        n = 0;
        while (!ack[1] && n < 20) begin @(negedge clk); n++; end
        chk("viol_ack_seen", 32'(ack[1]), 32'd1);
        n = 0;
        while (ack[1] && n < 20) begin @(negedge clk); n++; end
        chk("viol_ack_drop", 32'(ack[1]), 32'd0);

        // Whole-frame fill, then spot reads.
        call(1, 2'd3, 0, 0, 8'h3C, 32'h19, 1'b0, 259);
        call(0, 2'd1, 0, 0, 8'h00, 32'h3C, 1'b0, 3);
        call(1, 2'd1, 15, 15, 8'h00, 32'h3C, 1'b0, 3);
        call(0, 2'd1, 7, 9, 8'h00, 32'h3C, 1'b0, 3);

        // Simultaneous requests after reset. Each client re-requests at once;
        // the expected grant order is 0,1,0,1.
        do_reset();
        chk_reset_state();
        op = '0;
        push(0, 32'h19, 1'b0);
        push(1, 32'h19, 1'b0);
        push(0, 32'h19, 1'b0);
        push(1, 32'h19, 1'b0);
        rem[0] = 2; rem[1] = 2;
        req = 2'b11;
        for (int k = 0; k < 200 && (rem[0] > 0 || rem[1] > 0); k++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (req[c] && ack[c]) begin
                    req[c] = 1'b0;
                    rem[c]--;
                end else if (!req[c] && !ack[c] && rem[c] > 0) begin
                    req[c] = 1'b1;
                end
            end
        end
        chk("pair_done", 32'(rem[0] + rem[1]), 32'd0);
        req = '0;
        @(negedge clk);
        wait_idle();

        // Reset partway through a fill.
        op[1:0] = 2'd3; wdata[7:0] = 8'h55;
        req[0] = 1'b1;
        repeat (102) @(negedge clk);
        chk("fill_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("midfill_ack", 32'(ack), 32'd0);
        chk("midfill_busy", 32'(busy), 32'd0);
        chk("midfill_txn", txn_count, 32'd0);
        reset = 1'b0;
        sb.delete();
        exp_txn = 0;
        call(0, 2'd0, 0, 0, 8'h00, 32'h19, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kiwi_pixel_rpc_server.md
KIWI_PIXEL_RPC_SERVER -- requirements
Module: kiwi_pixel_rpc_server

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NCLIENTS, 2, number of client RPC channels (1..8)
- DATA_W, 8, pixel width in bits (1..32)
- WIDTH, 16, frame width in pixels
- HEIGHT, 16, frame height in pixels
- ID_VALUE, 32'h00000019, constant returned by GET_ID
REQ-002 Ports (name  direction  width  meaning), one per line; one clock, synchronous active-high reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  NCLIENTS  per-client request, 4-phase
- ack  out  NCLIENTS  per-client acknowledge
- op  in  2*NCLIENTS  per-client opcode: 0 GET_ID, 1 READ, 2 WRITE, 3 FILL
- x  in  32*NCLIENTS  per-client pixel x, unsigned
- y  in  32*NCLIENTS  per-client pixel y, unsigned
- wdata  in  DATA_W*NCLIENTS  per-client write/fill data
- rdata  out  32*NCLIENTS  per-client return value
- err  out  NCLIENTS  per-client out-of-range flag for last call
- busy  out  1  high whenever state is not IDLE
- txn_count  out  32  completed-call counter, wraps modulo 2^32
REQ-003 Client slice i occupies bits [(i+1)*w-1 : i*w] of each vector.

Function
REQ-004 Storage: WIDTH*HEIGHT words of DATA_W; address = y*WIDTH + x.
REQ-005 Handshake, 4-phase: client raises req[i] with op/x/y/wdata held stable; server raises ack[i] with rdata/err valid; client drops req[i]; server drops ack[i]; args may change only while req[i] and ack[i] are both low.
REQ-006 FSM states: IDLE, EXEC, FILL, ACK_HI, ACK_LO.
REQ-007 IDLE: if any req[i]=1 with ack[i]=0, grant one client round-robin (search starts at last grant+1, mod NCLIENTS; after reset, client 0 first); latch its op/x/y/wdata; go EXEC.
REQ-008 EXEC: GET_ID -> rdata=ID_VALUE; READ -> rdata=pixel zero-extended to 32; WRITE -> store wdata, rdata unchanged; FILL -> go FILL; other ops -> ACK_HI.
REQ-009 Range check for READ/WRITE: x>=WIDTH or y>=HEIGHT -> err=1, no write, rdata=0; otherwise err=0. GET_ID and FILL always set err=0.
REQ-010 FILL: write wdata to one address per cycle, ascending from 0 to WIDTH*HEIGHT-1, then ACK_HI; total FILL occupancy = WIDTH*HEIGHT cycles.
REQ-011 Latency: req seen in IDLE at edge t -> ack[i] high after edge t+2 for GET_ID/READ/WRITE; t+2+WIDTH*HEIGHT for FILL.
REQ-012 ACK_HI: ack[granted]=1; txn_count increments once on entry; stay until req[granted]=0, then go ACK_LO.
REQ-013 ACK_LO: ack=0 for one cycle, then IDLE; so a client re-asserting req is never served back-to-back while another client waits.
REQ-014 At most one ack bit is high at any time; rdata/err of non-granted clients hold their last values.
REQ-015 A req dropped before its ack (protocol violation) is ignored; the call completes and ack stays high until req is low, then proceeds normally.
REQ-016 Requests arriving during busy are queued only by the level of req; no request is lost or duplicated.

Reset
REQ-017 reset=1 at a rising edge: state=IDLE, ack=0, err=0, rdata=0, busy=0, txn_count=0, round-robin pointer to client 0; overrides everything, including mid-FILL and mid-ACK_HI.
REQ-018 Pixel memory is not cleared by reset; after a reset, contents are undefined until written or filled.

Verification
REQ-019 Scenario: client 0 GET_ID -> ack[0] at t+2, rdata[0]=32'h00000019, err[0]=0, txn_count=1.
REQ-020 Scenario: client 0 WRITE x=3,y=5,wdata=8'hA7; client 1 READ x=3,y=5 -> rdata[1]=32'h000000A7, err[1]=0.
REQ-021 Scenario: READ x=16,y=0 and WRITE x=0,y=16 (defaults) -> err=1, rdata=0, memory unchanged (re-read of (0,15) returns prior value).
REQ-022 Scenario: both clients raise req in the same cycle after reset -> client 0 acked first, client 1 acked next; repeat -> grant order alternates 0,1,0,1.
REQ-023 Scenario: FILL wdata=8'h3C -> ack after 2+256 cycles; READ of (0,0), (15,15), (7,9) each returns 32'h0000003C.
REQ-024 Scenario: reset asserted 100 cycles into FILL -> next cycle ack=0, busy=0, txn_count=0; fresh GET_ID completes normally.
